// File: rtl/multiplicador_32_bits_pkg.sv
// Shared constants and state encoding for the 32x32 shift-and-add multiplier.
package multiplicador_32_bits_pkg;

    localparam int unsigned OP_W   = 32;
    localparam int unsigned PROD_W = 2 * OP_W;
    localparam int unsigned ITER_N = 32;
    localparam int unsigned CNT_W  = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/somador_32_bits.sv
// 32-bit ripple adder with carry-in/out; Signal reports the sign bit of the sum.
module somador_32_bits (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Cin,
    output logic [31:0] S,
    output logic        Cout,
    output logic        Signal
);

    assign {Cout, S} = 33'(A) + 33'(B) + 33'(Cin);
    assign Signal    = S[31];

endmodule

// File: rtl/multiplicador_32_bits.sv
// Unsigned 32x32 -> 64 sequential multiplier, one shift-and-add step per CALC cycle.
module multiplicador_32_bits
    import multiplicador_32_bits_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [OP_W-1:0]   A,
    input  logic [OP_W-1:0]   B,
    output logic              busy,
    output logic              done,
    output logic [PROD_W-1:0] P,
    output logic              overflow
);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic [OP_W-1:0]     mcand_q, mcand_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [PROD_W-1:0]   p_q, p_d;
    logic                ovf_q, ovf_d;

    logic [OP_W-1:0]     addend;
    logic [OP_W-1:0]     add_sum;
    logic                add_cout;
    logic                add_signal_unused;
    logic [PROD_W-1:0]   shifted;

    // Multiplier LSB selects whether the multiplicand is accumulated this step
    assign addend = acc_q[0] ? mcand_q : '0;

    somador_32_bits u_somador (
        .A      (acc_q[PROD_W-1:OP_W]),
        .B      (addend),
        .Cin    (1'b0),
        .S      (add_sum),
        .Cout   (add_cout),
        .Signal (add_signal_unused)
    );

    // Carry-out re-enters at bit 63 as the 65-bit {cout,sum,low} value shifts right
    assign shifted = {add_cout, add_sum, acc_q[OP_W-1:1]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        p_d     = p_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CALC;
                    mcand_d = A;
                    acc_d   = {OP_W'(0), B};
                    cnt_d   = '0;
                end
            end
            CALC: begin
                acc_d = shifted;
                if (cnt_q == CNT_W'(ITER_N - 1)) begin
                    state_d = DONE;
                    p_d     = shifted;
                    ovf_d   = |shifted[PROD_W-1:OP_W];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == CALC);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            p_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            p_q     <= p_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign P        = p_q;
    assign overflow = ovf_q;

endmodule
